// File: rtl/output_deskew_buffer.sv
// output_deskew_buffer: realigns skewed systolic result lanes and queues aligned rows behind a valid/ready port
module output_deskew_buffer #(
  parameter int LANES      = 4,
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  input  logic [LANES*DATA_WIDTH-1:0]       in_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [LANES*DATA_WIDTH-1:0]       out_data,
  output logic                              stall_req,
  output logic [$clog2(FIFO_DEPTH):0]       count,
  output logic                              overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int W  = LANES * DATA_WIDTH;
  logic [W-1:0]     aligned;
  logic [LANES-2:0] vsr;
  logic             row_done;
  logic [W-1:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count_next;
  logic             full, pop, push;
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    localparam int D = LANES - 1 - i;
    if (D == 0) begin : g_pass
      assign aligned[DATA_WIDTH*(i+1)-1 -: DATA_WIDTH] = in_data[DATA_WIDTH*(i+1)-1 -: DATA_WIDTH];
    end else begin : g_dly
      logic [DATA_WIDTH-1:0] sr [D];
      // lane i waits LANES-1-i cycles so it lines up with the last lane
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) for (int k = 0; k < D; k++) sr[k] <= '0;
        else begin
          sr[0] <= in_data[DATA_WIDTH*(i+1)-1 -: DATA_WIDTH];
          for (int k = 1; k < D; k++) sr[k] <= sr[k-1];
        end
      assign aligned[DATA_WIDTH*(i+1)-1 -: DATA_WIDTH] = sr[D-1];
    end
  end
  // row-start strobe follows lane 0 through the full delay to mark a completed row
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) vsr <= '0;
    else begin
      vsr[0] <= in_valid;
      for (int k = 1; k <= LANES - 2; k++) vsr[k] <= vsr[k-1];
    end
  assign row_done   = vsr[LANES-2];
  assign out_valid  = count != '0;
  assign full       = count == (AW+1)'(FIFO_DEPTH);
  assign pop        = out_valid & out_ready;
  assign push       = row_done & (~full | pop);
  assign count_next = count + (AW+1)'(push) - (AW+1)'(pop);
  // storage array needs no reset; validity is tracked by count
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= aligned;
  // pointers, occupancy, flags and the registered head row
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      stall_req <= 1'b0;
      out_data  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count     <= count_next;
      overflow  <= overflow | (row_done & full & ~pop);
      stall_req <= (FIFO_DEPTH - int'(count_next)) <= LANES - 1;
      if (pop && count > 1) out_data <= mem[rd_ptr + AW'(1)];
      else if (push && (count == 0 || (pop && count == 1))) out_data <= aligned;
    end
endmodule

// File: tb/tb_output_deskew_buffer.sv
// tb_output_deskew_buffer: directed checks of deskew latency, FIFO ordering, backpressure, overflow and reset
module tb_output_deskew_buffer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [63:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_data;
  logic        stall_req;
  logic [3:0]  count;
  logic        overflow;
  int          passed = 0;
  int          total = 0;
  bit          hv [4];
  logic [15:0] hb [4];
  output_deskew_buffer #(.LANES(4), .DATA_WIDTH(16), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .stall_req(stall_req), .count(count), .overflow(overflow)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s got %h expected %h", tag, got, exp);
  endtask
  function automatic logic [63:0] rw(input logic [15:0] b);
    return {b + 16'd3, b + 16'd2, b + 16'd1, b};
  endfunction
  task automatic tick(input bit v, input logic [15:0] b, input bit rdy);
    for (int i = 3; i > 0; i--) begin
      hv[i] = hv[i-1];
      hb[i] = hb[i-1];
    end
    hv[0] = v;
    hb[0] = b;
    in_valid = v;
    for (int i = 0; i < 4; i++) in_data[16*i +: 16] = hv[i] ? hb[i] + 16'(i) : 16'h0;
    out_ready = rdy;
    @(posedge clk);
    @(negedge clk);
  endtask
  initial begin
    int sent;
    int cnt_at_stall;
    bit v;
    for (int i = 0; i < 4; i++) begin
      hv[i] = 1'b0;
      hb[i] = '0;
    end
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_stall", 64'(stall_req), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    tick(1'b1, 16'h10, 1'b1);
    for (int k = 1; k < 4; k++) begin
      chk("t1_not_yet", 64'(out_valid), 64'd0);
      tick(1'b0, 16'h0, 1'b1);
    end
    chk("t1_valid_c4", 64'(out_valid), 64'd1);
    chk("t1_data", out_data, 64'h0013_0012_0011_0010);
    tick(1'b0, 16'h0, 1'b1);
    chk("t1_valid_drop", 64'(out_valid), 64'd0);
    chk("t1_count0", 64'(count), 64'd0);
    chk("t1_data_hold", out_data, 64'h0013_0012_0011_0010);
    for (int k = 0; k < 12; k++) begin
      tick(k < 8, 16'(k * 16), 1'b1);
      chk("t2_valid", 64'(out_valid), 64'(k >= 3 && k < 11));
      if (k >= 3 && k < 11) chk("t2_data", out_data, rw(16'((k - 3) * 16)));
    end
    chk("t2_count", 64'(count), 64'd0);
    chk("t2_overflow", 64'(overflow), 64'd0);
    sent = 0;
    cnt_at_stall = -1;
    for (int k = 0; k < 14; k++) begin
      if (stall_req && cnt_at_stall < 0) cnt_at_stall = int'(count);
      v = !stall_req && sent < 12;
      tick(v, 16'(16'h100 + sent * 16), 1'b0);
      if (v) sent++;
    end
    chk("t3_stall_at", 64'(cnt_at_stall), 64'd5);
    chk("t3_sent", 64'(sent), 64'd8);
    chk("t3_count_peak", 64'(count), 64'd8);
    chk("t3_overflow", 64'(overflow), 64'd0);
    chk("t3_stall_high", 64'(stall_req), 64'd1);
    chk("t3_head", out_data, rw(16'h100));
    tick(1'b1, 16'h180, 1'b0);
    repeat (3) tick(1'b0, 16'h0, 1'b0);
    chk("t4_overflow", 64'(overflow), 64'd1);
    chk("t4_count", 64'(count), 64'd8);
    for (int j = 0; j < 8; j++) begin
      chk("t4_drain_valid", 64'(out_valid), 64'd1);
      chk("t4_drain_data", out_data, rw(16'(16'h100 + j * 16)));
      tick(1'b0, 16'h0, 1'b1);
    end
    chk("t4_empty", 64'(out_valid), 64'd0);
    chk("t4_count0", 64'(count), 64'd0);
    chk("t4_sticky", 64'(overflow), 64'd1);
    for (int k = 0; k < 11; k++) tick(k < 9, 16'(16'h200 + k * 16), 1'b0);
    chk("t5_full", 64'(count), 64'd8);
    chk("t5_head0", out_data, rw(16'h200));
    tick(1'b0, 16'h0, 1'b1);
    chk("t5_count_same", 64'(count), 64'd8);
    chk("t5_head1", out_data, rw(16'h210));
    for (int j = 1; j < 9; j++) begin
      chk("t5_drain_data", out_data, rw(16'(16'h200 + j * 16)));
      tick(1'b0, 16'h0, 1'b1);
    end
    chk("t5_empty", 64'(out_valid), 64'd0);
    for (int k = 0; k < 6; k++) tick(k < 5, 16'(16'h300 + k * 16), 1'b0);
    chk("t6_stored3", 64'(count), 64'd3);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 64'(out_valid), 64'd0);
    chk("t6_rst_count", 64'(count), 64'd0);
    chk("t6_rst_overflow", 64'(overflow), 64'd0);
    chk("t6_rst_data", out_data, 64'd0);
    for (int i = 0; i < 4; i++) hv[i] = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick(1'b0, 16'h0, 1'b1);
      chk("t6_no_stale", 64'(out_valid), 64'd0);
    end
    chk("t6_count_end", 64'(count), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
